// File: rtl/dmem_bus_arbiter.sv
// Two-master arbiter for the data RAM and LED/switch MMIO registers; one transaction per 3 cycles.
// Define ARB_FAIR_EN for round-robin tie breaking; otherwise port 0 wins every tie.
module dmem_bus_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [13:0] ram_a,
  output logic        ram_we,
  output logic [31:0] ram_d,
  input  logic [31:0] ram_spo,
  input  logic [23:0] device_sw,
  output logic [23:0] device_led
);

  localparam logic [31:0] LED_ADDR = 32'hFFFF_F060;
  localparam logic [31:0] SW_ADDR  = 32'hFFFF_F070;

  // Handshake: a master raises req with we/addr/wdata stable and holds it until its
  // one-cycle ack. A req still high in the IDLE cycle after the ack is a new request.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        gnt, gnt_nxt;
  logic        last_gnt, last_gnt_nxt;
  logic        tie_winner;
  logic        g_we;
  logic [31:0] g_addr;
  logic [31:0] g_wdata;
  logic        is_led, is_sw;
  logic [31:0] rd_result;
  logic [23:0] sw_meta, sw_sync;

`ifdef ARB_FAIR_EN
  assign tie_winner = ~last_gnt;
`else
  assign tie_winner = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    last_gnt_nxt = last_gnt;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_nxt    = ACCESS;
          gnt_nxt      = (m0_req && m1_req) ? tie_winner : m1_req;
          last_gnt_nxt = (m0_req && m1_req) ? tie_winner : m1_req;
        end
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign g_we    = gnt ? m1_we    : m0_we;
  assign g_addr  = gnt ? m1_addr  : m0_addr;
  assign g_wdata = gnt ? m1_wdata : m0_wdata;
  assign is_led  = (g_addr == LED_ADDR);
  assign is_sw   = (g_addr == SW_ADDR);

  // Output logic
  always_comb begin
    ram_a  = g_addr[15:2];
    ram_d  = g_wdata;
    ram_we = (state == ACCESS) && g_we && !is_led && !is_sw;
    m0_ack = (state == RESP) && !gnt;
    m1_ack = (state == RESP) && gnt;
  end

  // MMIO accesses return the register value; RAM writes return the pre-write word.
  always_comb begin
    rd_result = ram_spo;
    if (is_led) begin
      rd_result = {8'h00, device_led};
    end else if (is_sw) begin
      rd_result = {8'h00, sw_sync};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= device_sw;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      device_led <= '0;
    end else if (state == ACCESS) begin
      if (gnt) begin
        m1_rdata <= rd_result;
      end else begin
        m0_rdata <= rd_result;
      end
      if (g_we && is_led) begin
        device_led <= {8'h00, g_wdata[15:0]};
      end
    end
  end

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Bench for dmem_bus_arbiter: RAM stub, transaction-level reference model, per-cycle compare, directed tests.
module tb_dmem_bus_arbiter;

  localparam logic [31:0] LED_A = 32'hFFFF_F060;
  localparam logic [31:0] SW_A  = 32'hFFFF_F070;
`ifdef ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk, rst_n;
  logic        m0_req, m0_we, m0_ack, m1_req, m1_we, m1_ack;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [13:0] ram_a;
  logic        ram_we;
  logic [31:0] ram_d, ram_spo;
  logic [23:0] device_sw, device_led;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  dmem_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_a(ram_a), .ram_we(ram_we), .ram_d(ram_d), .ram_spo(ram_spo),
    .device_sw(device_sw), .device_led(device_led)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Single-port RAM stub: asynchronous read, write lands just after the edge.
  logic [31:0] ram_mem [0:16383];
  logic [13:0] stub_wa;
  logic [31:0] stub_wd;
  assign ram_spo = ram_mem[ram_a];
  initial for (int i = 0; i < 16384; i++) ram_mem[i] = '0;
  always @(posedge clk) begin
    if (ram_we) begin
      stub_wa = ram_a;
      stub_wd = ram_d;
      #1;
      ram_mem[stub_wa] = stub_wd;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: each granted transaction occupies three cycles from its grant edge;
  // its result is computed at grant time and committed in its ack cycle.
  logic [31:0] ref_mem [0:16383];
  initial for (int i = 0; i < 16384; i++) ref_mem[i] = '0;
  logic [31:0] exp_q[$];
  logic        port_q[$];
  logic [31:0] rd0 = '0, rd1 = '0;
  logic [23:0] led = '0, sw_prev = '0;
  logic        last = 1'b1;
  int          free_at = 0, ack_cyc = -1, we_cyc = -1;
  logic        ack_port = 1'b0;
  logic [13:0] we_a = '0;
  logic [31:0] we_d = '0;
  logic        pend_led_we = 1'b0, pend_ram_we = 1'b0;
  logic [23:0] pend_led = '0;
  logic [13:0] pend_a = '0;
  logic [31:0] pend_d = '0;
  logic        win, m_we, p;
  logic [31:0] m_addr, m_wdata, m_res;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      rd0 = '0; rd1 = '0; led = '0; sw_prev = '0; last = 1'b1;
      free_at = 0; ack_cyc = -1; we_cyc = -1;
      pend_led_we = 1'b0; pend_ram_we = 1'b0;
      exp_q.delete(); port_q.delete();
    end else begin
      if (cyc == ack_cyc && exp_q.size() > 0) begin
        p = port_q.pop_front();
        if (p) rd1 = exp_q.pop_front();
        else   rd0 = exp_q.pop_front();
        if (pend_led_we) led = pend_led;
        if (pend_ram_we) ref_mem[pend_a] = pend_d;
      end
      if (cyc >= free_at && (m0_req || m1_req)) begin
        if (m0_req && m1_req) win = FAIR ? !last : 1'b0;
        else                  win = m1_req;
        last    = win;
        m_we    = win ? m1_we    : m0_we;
        m_addr  = win ? m1_addr  : m0_addr;
        m_wdata = win ? m1_wdata : m0_wdata;
        pend_led_we = 1'b0;
        pend_ram_we = 1'b0;
        if (m_addr == LED_A) begin
          m_res = {8'h00, led};
          pend_led_we = m_we;
          pend_led = {8'h00, m_wdata[15:0]};
        end else if (m_addr == SW_A) begin
          m_res = {8'h00, sw_prev};
        end else begin
          m_res = ref_mem[m_addr[15:2]];
          pend_ram_we = m_we;
          pend_a = m_addr[15:2];
          pend_d = m_wdata;
        end
        exp_q.push_back(m_res);
        port_q.push_back(win);
        ack_cyc  = cyc + 1;
        ack_port = win;
        we_cyc   = pend_ram_we ? cyc : -1;
        we_a     = m_addr[15:2];
        we_d     = m_wdata;
        free_at  = cyc + 3;
      end
      sw_prev = device_sw;
    end
  end

  // Compare process
  int we_count = 0;
  logic [13:0] we_last_a = '0;
  int grant_log[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_m0_ack", m0_ack, 0);
      chk("rst_m1_ack", m1_ack, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_m0_rdata", m0_rdata, 0);
      chk("rst_m1_rdata", m1_rdata, 0);
      chk("rst_led", device_led, 0);
    end else begin
      chk("m0_ack", m0_ack, (cyc == ack_cyc) && !ack_port);
      chk("m1_ack", m1_ack, (cyc == ack_cyc) && ack_port);
      chk("ram_we", ram_we, cyc == we_cyc);
      if (cyc == we_cyc) begin
        chk("ram_a", ram_a, we_a);
        chk("ram_d", ram_d, we_d);
      end
      chk("m0_rdata", m0_rdata, rd0);
      chk("m1_rdata", m1_rdata, rd1);
      chk("device_led", device_led, led);
      if (m0_ack) grant_log.push_back(0);
      if (m1_ack) grant_log.push_back(1);
      if (ram_we) begin
        we_count++;
        we_last_a = ram_a;
      end
    end
  end

  // Driver: one transaction on one port, bounded wait for its ack.
  task automatic do_txn(input logic port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat);
    int start;
    logic got;
    @(posedge clk); #1;
    if (port) begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end
    start = cyc;
    got = 1'b0;
    lat = -1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (port ? m1_ack : m0_ack) begin
        got = 1'b1;
        lat = cyc - start;
      end
    end
    if (port) m1_req = 1'b0;
    else      m0_req = 1'b0;
    chk("txn_acked", got, 1);
  endtask

  int lat, wc0, gl0, a1, a2;
  logic seen, done;
  int exp_ord [4];

  initial begin
    if (FAIR) exp_ord = '{0, 1, 0, 1};
    else      exp_ord = '{0, 0, 0, 0};
    rst_n = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    device_sw = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_m0_rdata", m0_rdata, 0);
    chk("init_led", device_led, 0);
    chk("init_ram_we", ram_we, 0);
    rst_n = 1'b1;

    // RAM write then read-back on port 0
    @(posedge clk); #1;
    wc0 = we_count;
    do_txn(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, lat);
    chk("t1_wr_lat", lat, 2);
    @(posedge clk); #1;
    chk("t1_we_pulses", we_count - wc0, 1);
    chk("t1_we_addr", we_last_a, 14'd4);
    do_txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, lat);
    chk("t1_rd_lat", lat, 2);
    chk("t1_rdata", m0_rdata, 32'h1234_5678);

    // LED write and read on port 1
    @(posedge clk); #1;
    wc0 = we_count;
    do_txn(1'b1, 1'b1, LED_A, 32'hABCD_BEEF, lat);
    chk("t2_led", device_led, 24'h00BEEF);
    do_txn(1'b1, 1'b0, LED_A, 32'h0, lat);
    chk("t2_rdata", m1_rdata, 32'h0000_BEEF);
    @(posedge clk); #1;
    chk("t2_no_ram_we", we_count - wc0, 0);

    // Switch read through the synchronizer, then an ignored switch write
    device_sw = 24'h5A5A5A;
    repeat (3) @(posedge clk);
    do_txn(1'b0, 1'b0, SW_A, 32'h0, lat);
    chk("t3_sw_rdata", m0_rdata, 32'h005A_5A5A);
    @(posedge clk); #1;
    wc0 = we_count;
    do_txn(1'b0, 1'b1, SW_A, 32'hFFFF_FFFF, lat);
    chk("t3_sw_wr_lat", lat, 2);
    chk("t3_led_kept", device_led, 24'h00BEEF);
    @(posedge clk); #1;
    chk("t3_no_ram_we", we_count - wc0, 0);

    // Reset during the ACCESS cycle of a RAM write
    @(posedge clk); #1;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0000_0040; m1_wdata = 32'hDEAD_BEEF;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (ram_we) seen = 1'b1;
    end
    chk("t4_access_seen", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_ram_we_drop", ram_we, 0);
    chk("t4_no_ack", m1_ack, 0);
    chk("t4_led_clear", device_led, 0);
    m1_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Both ports request continuously
    @(posedge clk); #1;
    gl0 = grant_log.size();
    m0_we = 1'b0; m0_addr = 32'h0000_0100;
    m1_we = 1'b0; m1_addr = 32'h0000_0200;
    m0_req = 1'b1; m1_req = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(posedge clk); #1;
      if (grant_log.size() - gl0 >= 4) done = 1'b1;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    chk("t5_four_grants", done, 1);
    for (int i = 0; i < 4; i++) begin
      if (gl0 + i < grant_log.size()) chk("t5_grant_order", grant_log[gl0 + i], exp_ord[i]);
      else chk("t5_grant_missing", 0, 1);
    end

    // Port 0 holds req one cycle past its ack: a repeat transaction follows
    @(posedge clk); #1;
    m0_we = 1'b0; m0_addr = 32'h0000_0040; m0_req = 1'b1;
    a1 = -1; a2 = -1;
    for (int n = 0; n < 10 && a1 < 0; n++) begin
      @(negedge clk);
      if (m0_ack) a1 = cyc;
    end
    for (int n = 0; n < 10 && a2 < 0; n++) begin
      @(negedge clk);
      if (m0_ack) a2 = cyc;
    end
    m0_req = 1'b0;
    chk("t6_first_ack", a1 >= 0, 1);
    chk("t6_ack_spacing", a2 - a1, 3);
    chk("t6_aborted_write", m0_rdata, 32'h0);

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
